// File: rtl/fetch_queue.sv
// Instruction fetch stage: issues PC reads to a 1-cycle synchronous instruction memory
// and buffers returned {pc, instruction} pairs in a credit-managed FIFO for decode.
`timescale 1ns/1ps
module fetch_queue #(
  parameter int DEPTH  = 4,
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [ADDR_W-1:0]        pcIn,
  input  logic                     pcValid,
  output logic                     fetchStall,
  output logic [ADDR_W-1:0]        imemAddr,
  output logic                     imemReq,
  input  logic [WIDTH-1:0]         imemData,
  input  logic                     flush,
  output logic [WIDTH-1:0]         instrOut,
  output logic [ADDR_W-1:0]        instrPc,
  output logic                     instrValid,
  input  logic                     instrReady,
  output logic [$clog2(DEPTH):0]   fifoCount
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [CNT_W-1:0]  count_q, count_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic              inflight_q, inflight_d;
  logic [ADDR_W-1:0] pc_hold_q, pc_hold_d;
  logic [WIDTH-1:0]  instr_mem_q [DEPTH];
  logic [WIDTH-1:0]  instr_mem_d [DEPTH];
  logic [ADDR_W-1:0] pc_mem_q [DEPTH];
  logic [ADDR_W-1:0] pc_mem_d [DEPTH];

  logic [CNT_W:0]    credits_used;
  logic              accept;
  logic              push;
  logic              pop;

  // An in-flight read holds a credit, so the FIFO always has room when its data returns.
  always_comb begin
    credits_used = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q};
    fetchStall   = flush | (credits_used >= (CNT_W+1)'(DEPTH));
    accept       = pcValid & ~fetchStall;
    push         = inflight_q & ~flush;
    pop          = (count_q != '0) & instrReady & ~flush;
  end

  assign imemAddr   = pcIn;
  assign imemReq    = accept;
  assign instrValid = (count_q != '0);
  assign instrOut   = instr_mem_q[rd_ptr_q];
  assign instrPc    = pc_mem_q[rd_ptr_q];
  assign fifoCount  = count_q;

  always_comb begin
    count_d     = count_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    inflight_d  = accept;
    pc_hold_d   = accept ? pcIn : pc_hold_q;
    instr_mem_d = instr_mem_q;
    pc_mem_d    = pc_mem_q;
    if (flush) begin
      count_d    = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      inflight_d = 1'b0;
    end else begin
      if (push) begin
        instr_mem_d[wr_ptr_q] = imemData;
        pc_mem_d[wr_ptr_q]    = pc_hold_q;
        wr_ptr_d              = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      inflight_q <= 1'b0;
      pc_hold_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        instr_mem_q[i] <= '0;
        pc_mem_q[i]    <= '0;
      end
    end else begin
      count_q     <= count_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      inflight_q  <= inflight_d;
      pc_hold_q   <= pc_hold_d;
      instr_mem_q <= instr_mem_d;
      pc_mem_q    <= pc_mem_d;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Testbench for fetch_queue: directed vectors, a synchronous instruction memory model
// returning a+0x100, and a scoreboard monitor that checks every popped entry in order.
`timescale 1ns/1ps
module tb_fetch_queue;

  localparam int DEPTH  = 4;
  localparam int WIDTH  = 32;
  localparam int ADDR_W = 32;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [ADDR_W-1:0] pcIn = '0;
  logic              pcValid = 1'b0;
  logic              fetchStall;
  logic [ADDR_W-1:0] imemAddr;
  logic              imemReq;
  logic [WIDTH-1:0]  imemData = '0;
  logic              flush = 1'b0;
  logic [WIDTH-1:0]  instrOut;
  logic [ADDR_W-1:0] instrPc;
  logic              instrValid;
  logic              instrReady = 1'b0;
  logic [2:0]        fifoCount;

  int                vectors = 0;
  int                miscompares = 0;
  int                pop_count = 0;
  logic [31:0]       exp_q[$];

  fetch_queue #(.DEPTH(DEPTH), .WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .pcIn       (pcIn),
    .pcValid    (pcValid),
    .fetchStall (fetchStall),
    .imemAddr   (imemAddr),
    .imemReq    (imemReq),
    .imemData   (imemData),
    .flush      (flush),
    .instrOut   (instrOut),
    .instrPc    (instrPc),
    .instrValid (instrValid),
    .instrReady (instrReady),
    .fifoCount  (fifoCount)
  );

  always #5 clk = ~clk;

  // Synchronous instruction memory: imem[a] = a + 0x100, one cycle after the strobe.
  always @(posedge clk) begin
    if (imemReq) imemData <= imemAddr + 32'h100;
  end

  task automatic report_fail(input string name, input logic [31:0] actual, input logic [31:0] expected);
    miscompares++;
    $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) report_fail(name, actual, expected);
  endtask

  task automatic applyStimulus(input logic valid, input logic [31:0] pc, input logic ready, input logic fl);
    pcValid    = valid;
    pcIn       = pc;
    instrReady = ready;
    flush      = fl;
  endtask

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    reset = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Scoreboard monitor: accepted requests are queued, every pop is compared against the oldest.
  always @(negedge clk) begin
    if (reset || flush) begin
      exp_q.delete();
    end else begin
      if (instrValid && instrReady) begin
        if (exp_q.size() == 0) begin
          vectors++;
          report_fail("unexpected_pop", instrPc, 32'hFFFF_FFFF);
        end else begin
          logic [31:0] e;
          e = exp_q.pop_front();
          checkOutput("pop_pc", instrPc, e);
          checkOutput("pop_instr", instrOut, e + 32'h100);
          pop_count++;
        end
      end
      if (pcValid && !fetchStall) exp_q.push_back(pcIn);
    end
    if (fifoCount > 3'(DEPTH)) report_fail("fifo_overflow", 32'(fifoCount), DEPTH);
  end

  initial begin
    logic [31:0] pc;
    logic [5:0]  fill_stall_exp;
    int          accepted;

    // Reset state, observed before the first clock edge.
    #2;
    checkOutput("rst_valid", 32'(instrValid), 32'd0);
    checkOutput("rst_count", 32'(fifoCount), 32'd0);
    checkOutput("rst_stall", 32'(fetchStall), 32'd0);
    checkOutput("rst_instr", instrOut, 32'd0);
    checkOutput("rst_pc", instrPc, 32'd0);

    // Async reset with three entries queued.
    reset_dut;
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, 32'(k), 1'b0, 1'b0);
      next_cycle;
    end
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    next_cycle;
    checkOutput("midrst_count_before", 32'(fifoCount), 32'd3);
    #1 reset = 1'b1;
    #1;
    checkOutput("midrst_valid", 32'(instrValid), 32'd0);
    checkOutput("midrst_count", 32'(fifoCount), 32'd0);
    checkOutput("midrst_stall", 32'(fetchStall), 32'd0);
    checkOutput("midrst_pc", instrPc, 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;

    // Streaming at one fetch per cycle.
    reset_dut;
    for (int k = 0; k < 10; k++) begin
      applyStimulus(1'b1, 32'(k), 1'b1, 1'b0);
      @(negedge clk);
      checkOutput("stream_stall", 32'(fetchStall), 32'd0);
      if (k >= 2) begin
        checkOutput("stream_valid", 32'(instrValid), 32'd1);
        checkOutput("stream_pc", instrPc, 32'(k - 2));
        checkOutput("stream_instr", instrOut, 32'(k - 2) + 32'h100);
      end
      next_cycle;
    end
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    repeat (4) next_cycle;
    checkOutput("stream_drained", 32'(fifoCount), 32'd0);

    // Fill with decode stalled, then release; credits exhausted with push+pop together.
    reset_dut;
    pc = 32'h0;
    fill_stall_exp = 6'b110000;
    for (int k = 0; k < 6; k++) begin
      applyStimulus(1'b1, pc, 1'b0, 1'b0);
      @(negedge clk);
      checkOutput("fill_stall", 32'(fetchStall), 32'(fill_stall_exp[k]));
      if (k == 4) checkOutput("fill_count_c4", 32'(fifoCount), 32'd3);
      if (k == 5) begin
        checkOutput("full_count", 32'(fifoCount), 32'd4);
        checkOutput("full_head_pc", instrPc, 32'd0);
        checkOutput("full_head_instr", instrOut, 32'h100);
      end
      if (k < 4) pc = pc + 32'd1;
      next_cycle;
    end
    applyStimulus(1'b1, 32'd4, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("first_pop_stall", 32'(fetchStall), 32'd1);
    next_cycle;
    applyStimulus(1'b1, 32'd4, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("after_pop_stall", 32'(fetchStall), 32'd0);
    next_cycle;
    applyStimulus(1'b1, 32'd5, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("credit_full_stall", 32'(fetchStall), 32'd1);
    checkOutput("credit_full_count", 32'(fifoCount), 32'd3);
    next_cycle;
    applyStimulus(1'b1, 32'd5, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("pushpop_count", 32'(fifoCount), 32'd3);
    checkOutput("pushpop_head", instrPc, 32'd2);
    checkOutput("pushpop_stall", 32'(fetchStall), 32'd0);
    next_cycle;
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    repeat (8) next_cycle;
    checkOutput("fill_drained", 32'(fifoCount), 32'd0);

    // Flush in the cycle pc=7 data returns, then redirect to 0x40.
    reset_dut;
    for (int k = 5; k < 8; k++) begin
      applyStimulus(1'b1, 32'(k), 1'b1, 1'b0);
      next_cycle;
    end
    applyStimulus(1'b1, 32'd8, 1'b1, 1'b1);
    @(negedge clk);
    checkOutput("flush_stall", 32'(fetchStall), 32'd1);
    checkOutput("flush_head", instrPc, 32'd6);
    next_cycle;
    applyStimulus(1'b1, 32'h40, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("postflush_valid", 32'(instrValid), 32'd0);
    checkOutput("postflush_count", 32'(fifoCount), 32'd0);
    checkOutput("postflush_stall", 32'(fetchStall), 32'd0);
    next_cycle;
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("redirect_wait", 32'(instrValid), 32'd0);
    next_cycle;
    @(negedge clk);
    checkOutput("redirect_valid", 32'(instrValid), 32'd1);
    checkOutput("redirect_pc", instrPc, 32'h40);
    checkOutput("redirect_instr", instrOut, 32'h140);
    next_cycle;
    repeat (2) next_cycle;

    // Pointer wrap: 3*DEPTH+1 entries with random decode back-pressure.
    reset_dut;
    pop_count = 0;
    accepted  = 0;
    pc        = 32'h200;
    for (int c = 0; c < 400 && (accepted < 3*DEPTH+1 || exp_q.size() != 0 || fifoCount != 0); c++) begin
      applyStimulus(accepted < 3*DEPTH+1, pc,
                    (accepted < 3*DEPTH+1) ? 1'($urandom_range(0, 1)) : 1'b1, 1'b0);
      @(negedge clk);
      if (pcValid && !fetchStall) begin
        accepted++;
        pc = pc + 32'd1;
      end
      next_cycle;
    end
    checkOutput("wrap_accepted", 32'(accepted), 32'(3*DEPTH+1));
    checkOutput("wrap_pops", 32'(pop_count), 32'(3*DEPTH+1));
    checkOutput("wrap_left", 32'(exp_q.size()), 32'd0);
    checkOutput("wrap_count", 32'(fifoCount), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
